// File: rtl/spi_word_rx_pkg.sv
// Shared constants and types for the SPI word receiver.
// Covers command codes, field widths and the frame parser state encoding.
package spi_word_rx_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 64;
    localparam int BANK_W = 2;
    localparam int POS_W  = ADDR_W - BANK_W;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_CTRL   = 8'h02;
    localparam logic [7:0] CMD_CLRERR = 8'h03;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_SKIP
    } state_t;

    typedef enum logic {
        TGT_WORD,
        TGT_CTRL
    } target_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronises SCK/CS_N/MOSI into the clk domain and flags SCK rising edges.
// CS_N resets to "selected" so that a frame in progress at reset is never seen as idle.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign cs_n_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave that parses cmd/addr/data frames into 64-bit word strobes
// and a control register for the HUB75 image mask stage.
module spi_word_rx
    import spi_word_rx_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [63:0] CTRL_RESET  = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              o_ena,
    output logic [ADDR_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_data,
    output logic [WORD_W-1:0] o_ctrl,
    output logic              o_frame_err
);

    logic sck_rise, cs_n_s, mosi_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sck_rise (sck_rise),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s)
    );

    state_t              state, state_nx;
    target_t             target, target_nx;
    logic [5:0]          cnt, cnt_nx;
    logic [7:0]          cmd_sh, cmd_nx;
    logic [ADDR_W-1:0]   addr_reg, addr_nx;
    logic [WORD_W-1:0]   shreg, sh_nx;
    logic                ena_nx;
    logic [ADDR_W-1:0]   oaddr_nx;
    logic [WORD_W-1:0]   odata_nx;
    logic [WORD_W-1:0]   ctrl_nx;
    logic                err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT_IDLE;
            target      <= TGT_WORD;
            cnt         <= '0;
            cmd_sh      <= '0;
            addr_reg    <= '0;
            shreg       <= '0;
            o_ena       <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
            o_ctrl      <= CTRL_RESET;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            target      <= target_nx;
            cnt         <= cnt_nx;
            cmd_sh      <= cmd_nx;
            addr_reg    <= addr_nx;
            shreg       <= sh_nx;
            o_ena       <= ena_nx;
            o_addr      <= oaddr_nx;
            o_data      <= odata_nx;
            o_ctrl      <= ctrl_nx;
            o_frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        target_nx = target;
        cnt_nx    = cnt;
        cmd_nx    = cmd_sh;
        addr_nx   = addr_reg;
        sh_nx     = shreg;
        ena_nx    = 1'b0;
        oaddr_nx  = o_addr;
        odata_nx  = o_data;
        ctrl_nx   = o_ctrl;
        err_nx    = o_frame_err;

        case (state)
            ST_WAIT_IDLE: begin
                if (cs_n_s) state_nx = ST_CMD;
            end
            ST_CMD: begin
                if (!cs_n_s && sck_rise) begin
                    cmd_nx = {cmd_sh[6:0], mosi_s};
                    cnt_nx = cnt + 6'd1;
                    if (cnt[2:0] == 3'd7) begin
                        cnt_nx = '0;
                        case (cmd_nx)
                            CMD_WRITE: state_nx = ST_ADDR;
                            CMD_CTRL: begin
                                state_nx  = ST_DATA;
                                target_nx = TGT_CTRL;
                            end
                            CMD_CLRERR: begin
                                err_nx   = 1'b0;
                                state_nx = ST_SKIP;
                            end
                            default: begin
                                err_nx   = 1'b1;
                                state_nx = ST_SKIP;
                            end
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (sck_rise) begin
                    addr_nx = {addr_reg[ADDR_W-2:0], mosi_s};
                    cnt_nx  = cnt + 6'd1;
                    if (cnt[2:0] == 3'd7) begin
                        cnt_nx    = '0;
                        state_nx  = ST_DATA;
                        target_nx = TGT_WORD;
                    end
                end
            end
            ST_DATA: begin
                if (sck_rise) begin
                    sh_nx  = {shreg[WORD_W-2:0], mosi_s};
                    cnt_nx = cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        if (target == TGT_WORD) begin
                            ena_nx   = 1'b1;
                            oaddr_nx = addr_reg;
                            odata_nx = sh_nx;
                            // bursts advance within the current bank only
                            addr_nx  = {addr_reg[ADDR_W-1:POS_W], addr_reg[POS_W-1:0] + 6'd1};
                        end else begin
                            ctrl_nx  = sh_nx;
                            state_nx = ST_SKIP;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Deselect wins after any same-cycle edge has been taken into account.
        if (cs_n_s && state != ST_WAIT_IDLE) begin
            if (state_nx == ST_ADDR || (state_nx == ST_DATA && cnt_nx != 6'd0))
                err_nx = 1'b1;
            state_nx = ST_CMD;
            cnt_nx   = '0;
        end
    end

endmodule
